// File: rtl/ising_gibbs_engine.sv
// Sequential Gibbs sampler for an N-spin Ising model: one coupling term per cycle, spin set from sign(field + LFSR noise).
// Define ISING_ANNEAL_EN to increment the latched noise_shift at every sweep boundary (saturating at 15).
module ising_gibbs_engine #(
   parameter int          N          = 4,
   parameter int          DATABITS   = 16,
   parameter int          SWEEP_BITS = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_we,
   input  logic [$clog2(N)-1:0]        cfg_row,
   input  logic [$clog2(N)-1:0]        cfg_col,
   input  logic signed [DATABITS-1:0]  cfg_data,
   input  logic                        spin_init_we,
   input  logic [N-1:0]                spin_init,
   input  logic                        start,
   input  logic [SWEEP_BITS-1:0]       num_sweeps,
   input  logic [3:0]                  noise_shift,
   output logic                        busy,
   output logic                        done,
   output logic [N-1:0]                spins,
   output logic [DATABITS*N-1:0]       field_output
);

   localparam int IW = $clog2(N);
   localparam int AW = DATABITS + IW + 1;
   localparam int SW = ((AW > 16) ? AW : 16) + 1;
   localparam logic signed [AW-1:0] FMAX = {{(IW+2){1'b0}}, {(DATABITS-1){1'b1}}};
   localparam logic signed [AW-1:0] FMIN = {{(IW+2){1'b1}}, {(DATABITS-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic signed [DATABITS-1:0]  j_q [N][N];
   logic signed [DATABITS-1:0]  j_d [N][N];
   logic signed [DATABITS-1:0]  field_q [N];
   logic signed [DATABITS-1:0]  field_d [N];
   logic [N-1:0]                spins_q, spins_d;
   logic [15:0]                 lfsr_q, lfsr_d;
   logic [IW-1:0]               i_q, i_d, col_q, col_d;
   logic signed [AW-1:0]        acc_q, acc_d;
   logic [SWEEP_BITS-1:0]       sweep_q, sweep_d, nsw_q, nsw_d;
   logic [3:0]                  shift_q, shift_d;
   logic                        done_q, done_d;

   logic                        idle_ok;
   logic signed [DATABITS-1:0]  j_sel;
   logic signed [AW-1:0]        j_ext, term;
   logic signed [15:0]          noise16;
   logic signed [SW-1:0]        sum_w;
   logic signed [DATABITS-1:0]  field_sat;
   logic [SWEEP_BITS-1:0]       sweep_inc;
   logic                        lfsr_fb;

   // The done cycle sits in IDLE, so host requests are still refused until it has passed.
   assign idle_ok = (state_q == S_IDLE) && !done_q;

   always_comb begin
      j_sel     = j_q[i_q][col_q];
      j_ext     = {{(AW-DATABITS){j_sel[DATABITS-1]}}, j_sel};
      term      = (col_q == i_q) ? '0 : (spins_q[col_q] ? j_ext : -j_ext);
      noise16   = $signed(lfsr_q) >>> shift_q;
      sum_w     = {{(SW-AW){acc_q[AW-1]}}, acc_q} + {{(SW-16){noise16[15]}}, noise16};
      field_sat = (acc_q > FMAX) ? FMAX[DATABITS-1:0] :
                  (acc_q < FMIN) ? FMIN[DATABITS-1:0] : acc_q[DATABITS-1:0];
      sweep_inc = sweep_q + 1'b1;
      lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   end

   // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      field_d = field_q;
      spins_d = spins_q;
      lfsr_d  = lfsr_q;
      i_d     = i_q;
      col_d   = col_q;
      acc_d   = acc_q;
      sweep_d = sweep_q;
      nsw_d   = nsw_q;
      shift_d = shift_q;
      done_d  = (state_q == S_DONE);

      unique case (state_q)
         S_IDLE: begin
            if (idle_ok) begin
               if (cfg_we && (int'(cfg_row) < N) && (int'(cfg_col) < N)) begin
                  j_d[cfg_row][cfg_col] = cfg_data;
               end
               if (spin_init_we) begin
                  spins_d = spin_init;
               end
               if (start) begin
                  nsw_d   = num_sweeps;
                  shift_d = noise_shift;
                  i_d     = '0;
                  col_d   = '0;
                  acc_d   = '0;
                  sweep_d = '0;
                  state_d = (num_sweeps == '0) ? S_DONE : S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            acc_d = acc_q + term;
            if (col_q == IW'(N-1)) begin
               col_d   = '0;
               state_d = S_UPDATE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         S_UPDATE: begin
            spins_d[i_q] = (sum_w >= 0);
            field_d[i_q] = field_sat;
            lfsr_d       = {lfsr_q[14:0], lfsr_fb};
            acc_d        = '0;
            state_d      = S_ACCUM;
            if (i_q == IW'(N-1)) begin
               i_d     = '0;
               sweep_d = sweep_inc;
`ifdef ISING_ANNEAL_EN
               shift_d = (shift_q == 4'd15) ? shift_q : shift_q + 4'd1;
`else
               shift_d = shift_q;
`endif
               if (sweep_inc == nsw_q) begin
                  state_d = S_DONE;
               end
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         // NOTE: the coupling matrix is reset as registers because the run must start from J = 0 after reset.
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               j_q[r][c] <= '0;
            end
            field_q[r] <= '0;
         end
         spins_q <= '0;
         lfsr_q  <= LFSR_SEED;
         i_q     <= '0;
         col_q   <= '0;
         acc_q   <= '0;
         sweep_q <= '0;
         nsw_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         field_q <= field_d;
         spins_q <= spins_d;
         lfsr_q  <= lfsr_d;
         i_q     <= i_d;
         col_q   <= col_d;
         acc_q   <= acc_d;
         sweep_q <= sweep_d;
         nsw_q   <= nsw_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q != S_IDLE) || done_q;
   assign done  = done_q;
   assign spins = spins_q;

   for (genvar g = 0; g < N; g++) begin : g_field
      assign field_output[DATABITS*g +: DATABITS] = field_q[g];
   end

endmodule

// File: tb/tb_ising_gibbs_engine.sv
// Self-checking bench for ising_gibbs_engine (N=4): a whole-run behavioural model plus hand-computed literal expectations.
module tb_ising_gibbs_engine;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_row = '0, cfg_col = '0;
   logic signed [15:0] cfg_data = '0;
   logic        spin_init_we = 1'b0;
   logic [3:0]  spin_init = '0;
   logic        start = 1'b0;
   logic [7:0]  num_sweeps = '0;
   logic [3:0]  noise_shift = '0;
   logic        busy, done;
   logic [3:0]  spins;
   logic [63:0] field_output;

   ising_gibbs_engine dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
      .cfg_data(cfg_data), .spin_init_we(spin_init_we), .spin_init(spin_init), .start(start),
      .num_sweeps(num_sweeps), .noise_shift(noise_shift), .busy(busy), .done(done),
      .spins(spins), .field_output(field_output)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int        mj [4][4];
   bit [3:0]  base_spins;
   int        base_field [4];
   bit [15:0] m_lfsr;
   bit [3:0]  hist_spins [64];
   int        hist_field [64][4];
   int        run_k, run_len, run_upd;
   bit        run_active;
   bit        chk_en;

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic bit [15:0] lfsr_next(input bit [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) mj[r][c] = 0;
         base_field[r] = 0;
      end
      base_spins = '0;
      m_lfsr     = 16'hACE1;
      run_active = 0;
   endtask

   // Whole run as plain arithmetic: a snapshot of spins/fields after each spin update.
   task automatic model_run(input int ns, input int sh);
      bit [3:0] s;
      int f [4];
      int acc, noise, shv;
      logic signed [15:0] ls;
      s = base_spins;
      for (int k = 0; k < 4; k++) f[k] = base_field[k];
      for (int u = 0; u < ns * N; u++) begin
         int i = u % N;
         acc = 0;
         for (int j = 0; j < N; j++)
            if (j != i) acc += s[j] ? mj[i][j] : -mj[i][j];
         shv = sh;
`ifdef ISING_ANNEAL_EN
         shv = (sh + u / N > 15) ? 15 : sh + u / N;
`endif
         ls    = m_lfsr;
         noise = ls >>> shv;
         s[i]  = (acc + noise >= 0);
         f[i]  = sat16(acc);
         m_lfsr = lfsr_next(m_lfsr);
         hist_spins[u] = s;
         for (int k = 0; k < 4; k++) hist_field[u][k] = f[k];
      end
      run_upd = ns * N;
   endtask

   // ---------------- per-cycle compare ----------------
   int       c_e, c_n;
   bit       c_busy, c_done;
   bit [3:0] c_spins;
   int       c_field [4];

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         if (run_active && (cyc - run_k > run_len + 1)) begin
            if (run_upd > 0) begin
               base_spins = hist_spins[run_upd-1];
               for (int k = 0; k < 4; k++) base_field[k] = hist_field[run_upd-1][k];
            end
            run_active = 0;
         end
         c_busy  = 0;
         c_done  = 0;
         c_spins = base_spins;
         for (int k = 0; k < 4; k++) c_field[k] = base_field[k];
         if (run_active) begin
            c_e    = cyc - run_k;
            c_busy = 1;
            c_done = (c_e == run_len + 1);
            c_n    = c_e / (N + 1);
            if (c_n > run_upd) c_n = run_upd;
            if (c_n > 0) begin
               c_spins = hist_spins[c_n-1];
               for (int k = 0; k < 4; k++) c_field[k] = hist_field[c_n-1][k];
            end
         end
         check("busy", busy, c_busy);
         check("done", done, c_done);
         check("spins", spins, c_spins);
         for (int k = 0; k < 4; k++)
            check($sformatf("field%0d", k), $signed(field_output[16*k +: 16]), c_field[k]);
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (busy && g < 400) begin
         @(negedge clk);
         g++;
      end
   endtask

   task automatic write_j(input int r, input int c, input int d);
      wait_idle();
      cfg_we = 1'b1; cfg_row = r[1:0]; cfg_col = c[1:0]; cfg_data = d[15:0];
      @(posedge clk); #1;
      cfg_we = 1'b0;
      mj[r][c] = d;
   endtask

   task automatic load_spins(input logic [3:0] v);
      wait_idle();
      spin_init_we = 1'b1; spin_init = v;
      @(posedge clk); #1;
      spin_init_we = 1'b0;
      base_spins = v;
   endtask

   task automatic start_run(input int ns, input int sh, input bit ld, input logic [3:0] init);
      wait_idle();
      start = 1'b1; num_sweeps = ns[7:0]; noise_shift = sh[3:0];
      spin_init_we = ld; spin_init = init;
      @(posedge clk); #1;
      start = 1'b0; spin_init_we = 1'b0;
      if (ld) base_spins = init;
      model_run(ns, sh);
      run_k      = cyc;
      run_len    = ns * N * (N + 1);
      run_active = 1;
   endtask

   task automatic wait_done(input int exp_lat, input string nm);
      int cnt = 0;
      while (cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
         if (done) break;
      end
      check(nm, cyc - run_k, exp_lat);
   endtask

   task automatic fill_j(input int off, input int diag);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            write_j(r, c, (r == c) ? diag : off);
   endtask

   function automatic int fld(input int k);
      return $signed(field_output[16*k +: 16]);
   endfunction

   initial begin
      model_reset();
      chk_en = 0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_spins", spins, 0);
      check("rst_fields", (field_output == 64'd0), 1);
      #20 rst_n = 1'b1;
      chk_en = 1;

      // Ferromagnet; diagonal holds junk that must not contribute; spin load shares the start cycle.
      fill_j(100, 7777);
      start_run(1, 15, 1'b1, 4'b0001);
      wait_done(21, "lat_ferro");
      check("ferro_spins", spins, 4'b0000);
      for (int k = 0; k < 4; k++) check($sformatf("ferro_f%0d", k), fld(k), -300);

      // Antiferromagnet.
      fill_j(-100, 0);
      load_spins(4'b0000);
      start_run(1, 15, 1'b0, 4'b0000);
      wait_done(21, "lat_afm");
      check("afm_spins", spins, 4'b0011);
      check("afm_f0", fld(0), 300);
      check("afm_f1", fld(1), 100);
      check("afm_f2", fld(2), -100);
      check("afm_f3", fld(3), -100);

      // Positive saturation over two sweeps.
      fill_j(32767, 0);
      load_spins(4'b1111);
      start_run(2, 15, 1'b0, 4'b0000);
      wait_done(41, "lat_sat");
      check("sat_spins", spins, 4'b1111);
      for (int k = 0; k < 4; k++) check($sformatf("sat_f%0d", k), fld(k), 32767);

      // Negative couplings at the limit: lower clamp, exact -32768 and upper clamp.
      fill_j(-32768, 0);
      start_run(1, 15, 1'b0, 4'b0000);
      wait_done(21, "lat_nsat");
      check("nsat_spins", spins, 4'b1100);
      check("nsat_f0", fld(0), -32768);
      check("nsat_f1", fld(1), -32768);
      check("nsat_f2", fld(2), 32767);
      check("nsat_f3", fld(3), 32767);

      // Zero sweeps.
      start_run(0, 15, 1'b0, 4'b0000);
      wait_done(1, "lat_zero");
      check("zero_spins", spins, 4'b1100);

      // Busy guard: requests mid-run and in the done cycle are dropped.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            write_j(r, c, (r == 0 && c == 1) ? 1000 : (r * 4 + c) * 37 - 200);
      start_run(3, 4, 1'b1, 4'b0101);
      repeat (10) @(negedge clk);
      start = 1'b1; num_sweeps = 8'd5; cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd1;
      cfg_data = 16'sd0; spin_init_we = 1'b1; spin_init = 4'b1010;
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0; spin_init_we = 1'b0;
      wait_done(61, "lat_guard");
      start = 1'b1; num_sweeps = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      start_run(1, 2, 1'b0, 4'b0000);
      wait_done(21, "lat_after_guard");

      // Abort mid-run (sweep 1), then a fresh run from reset state.
      start_run(2, 15, 1'b0, 4'b0000);
      repeat (25) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_spins", spins, 0);
      check("abort_fields", (field_output == 64'd0), 1);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      start_run(1, 15, 1'b0, 4'b0000);
      wait_done(21, "lat_post_abort");
      check("tie_spins", spins, 4'b1010);
      check("tie_fields", (field_output == 64'd0), 1);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
